serial_to_parallel_rx: RTL and testbench
========================================

Name: serial_to_parallel_rx

Overview:
- Serial-in/parallel-out word receiver.
- Receiving end of the team's parallel-load shift transmitter: collects bit-strobed serial data into a WIDTH-bit word, MSB-first or LSB-first.
- Presents each completed word on a valid/ready output port.
- Sits between a serial link and the byte-wide datapath.

Parameters:
- WIDTH, 8, word width in bits (>= 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  bit strobe; s_in sampled on an edge where s_valid=1.
- start  input  1  frame start pulse; begins a new word.
- dir  input  1  0 = MSB-first (left-shift order), 1 = LSB-first (right-shift order); sampled only on start.
- q_out  output  WIDTH  assembled word (registered).
- q_valid  output  1  q_out holds an unconsumed word.
- q_ready  input  1  consumer accepts q_out on an edge where q_valid=1 and q_ready=1.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  parity result for the word on q_out; tied 0 without the macro.

Behaviour:
- Reset (sync, highest priority, also mid-frame): state=IDLE, shift reg=0, bit_cnt=0, dir_q=0, q_out=0, q_valid=0, overrun=0, parity_err=0.
- Internal shift register separate from q_out, so a new frame can be received while q_valid is pending.

State machine:
- IDLE -> SHIFT on start=1.
  - Latch dir into dir_q; bit_cnt=0.
  - s_valid in the start cycle is ignored.
  - s_valid in IDLE is ignored.
- SHIFT, on s_valid=1:
  - MSB-first: sr <= {sr[W-2:0], s_in}.
  - LSB-first: sr <= {s_in, sr[W-1:1]}.
  - bit_cnt += 1.
  - Cycles with s_valid=0 hold all state (gaps allowed, no timeout).
- Completion: s_valid=1 with bit_cnt=WIDTH-1.
  - Final shifted word is written to q_out on that same edge, q_valid=1, state=IDLE. Latency is 0 cycles after the last bit edge.
  - With the macro enabled, the state goes to PARITY instead.
- start=1 while in SHIFT (or PARITY): abort the partial word, relatch dir, bit_cnt=0, stay in SHIFT. No output, no overrun.
- start and s_valid in the same SHIFT cycle: start wins; the bit is discarded.

Output handshake:
- q_valid stays high and q_out stays stable until an edge with q_ready=1, which clears q_valid.
- Completion with q_valid=0: load the word.
- Completion with q_valid=1 and q_ready=1 on the same edge: load the new word, q_valid stays 1, no overrun.
- Completion with q_valid=1 and q_ready=0: new word discarded, q_out unchanged, overrun <= 1 until reset.
- bit_cnt width: clog2(WIDTH); it never exceeds WIDTH-1.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - After WIDTH data bits, the FSM enters PARITY and waits for one more s_valid bit (the parity bit); this edge is the completion edge.
  - parity_err = XOR(data bits, parity bit), i.e. 1 on even-parity failure.
  - parity_err loads together with q_out under the same rules as q_out (unchanged on overrun).
  - The word is still delivered when parity fails.
- Undefined:
  - No PARITY state.
  - parity_err is constant 0.

Test Plan:
- Reset -> q_out=0x00, q_valid=0, busy=0, overrun=0, parity_err=0.
- start(dir=0), then bits 1,0,1,0,0,1,1,0 on consecutive s_valid cycles -> q_out=0xA6 and q_valid=1 at the 8th-bit edge. Hold q_ready=0 for 5 cycles -> word held. q_ready=1 -> q_valid=0 next edge.
- Bits 1,0,0,0,0,0,0,0 with dir=1 -> q_out=0x01; same bits with dir=0 -> q_out=0x80. Repeat with 2-cycle s_valid gaps -> identical results.
- 3 bits sent, then start, then a full 8-bit frame 0x5A -> q_out=0x5A; the partial word is never presented.
- Two frames 0x11 then 0x22 with q_ready=0 -> q_out=0x11, overrun=1. Next test: q_ready=1 on the 0x22 completion edge -> q_out=0x22, q_valid=1, overrun=0.
- Reset asserted after 4 bits -> all outputs cleared, busy=0; next frame 0xC3 received correctly. With the macro: 0xC3 plus parity bit 0 -> parity_err=0; plus parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
// Serial-in/parallel-out word receiver. It collects bit-strobed serial data
// into a WIDTH-bit word, MSB-first or LSB-first, and presents each completed
// word on a valid/ready output port.
// Optional feature macro: SERIAL_RX_PARITY_EN. When defined, a trailing even
// parity bit follows each word and parity_err reports the check result.
// Without it, parity_err is tied to 0.

module serial_to_parallel_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_q;
  logic             accept_new;

`ifdef SERIAL_RX_PARITY_EN
  logic parity_q;
  logic parity_calc;

  // Even parity over the buffered data word plus the incoming parity bit.
  assign parity_calc = (^sr) ^ s_in;
  assign parity_err  = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  // The output slot can take a new word if it is empty or being drained now.
  assign accept_new = !q_valid || q_ready;
  assign busy       = (state != IDLE);

  // Next shift-register value for the bit presented on s_in, in dir_q order.
  always_comb begin
    sr_next = sr;
    if (dir_q) begin
      sr_next = {s_in, sr[WIDTH-1:1]};
    end else begin
      sr_next = {sr[WIDTH-2:0], s_in};
    end
  end

  // Receive FSM plus output register and handshake; start always restarts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      dir_q    <= 1'b0;
      q_out    <= '0;
      q_valid  <= 1'b0;
      overrun  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            dir_q   <= dir;
            bit_cnt <= '0;
            sr      <= '0;
          end
        end

        SHIFT: begin
          if (start) begin
            dir_q   <= dir;
            bit_cnt <= '0;
            sr      <= '0;
          end else if (s_valid) begin
            sr <= sr_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= IDLE;
              if (accept_new) begin
                q_out   <= sr_next;
                q_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (start) begin
            state   <= SHIFT;
            dir_q   <= dir;
            bit_cnt <= '0;
            sr      <= '0;
          end else if (s_valid) begin
            state <= IDLE;
            if (accept_new) begin
              q_out    <= sr;
              q_valid  <= 1'b1;
              parity_q <= parity_calc;
            end else begin
              overrun  <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx
// Scoreboard bench for serial_to_parallel_rx. Stimulus pushes the expected
// word, parity result and presentation cycle into a queue; a monitor pops an
// entry each time the DUT presents a new word. Honours SERIAL_RX_PARITY_EN.

module tb_serial_to_parallel_rx;

  typedef struct {
    logic [7:0] word;
    logic       par;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       s_in;
  logic       s_valid;
  logic       start;
  logic       dir;
  logic [7:0] q_out;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int   checks;
  int   failures;
  int   cycle;
  exp_t exp_q[$];
  exp_t cur;
  bit   presented;

  serial_to_parallel_rx #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .start      (start),
    .dir        (dir),
    .q_out      (q_out),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to check zero-latency word presentation.
  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of stimulus");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per newly presented word, then checks the
  // word stays stable until the consumer takes it.
  always @(negedge clk) begin
    if (reset) begin
      presented = 1'b0;
    end else if (q_valid) begin
      if (!presented) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", {24'd0, q_out}, 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          check_output("word", {24'd0, q_out}, {24'd0, cur.word});
          check_output("parity_err", {31'd0, parity_err}, {31'd0, cur.par});
          check_output("latency_cycle", cycle, cur.cyc);
        end
        presented = 1'b1;
      end else begin
        check_output("word_hold", {24'd0, q_out}, {24'd0, cur.word});
      end
      if (q_ready) begin
        presented = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_start(input logic d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    s_in    = b;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  // Final strobe of a frame: optionally push the expectation and raise q_ready
  // exactly on the completion edge.
  task automatic send_last(input logic b, input int gap, input logic [7:0] exp_word,
                           input logic exp_par, input bit push, input bit ready_last);
    exp_t e;
    repeat (gap) tick();
    s_in    = b;
    s_valid = 1'b1;
    if (ready_last) q_ready = 1'b1;
    if (push) begin
      e.word = exp_word;
      e.par  = exp_par;
      e.cyc  = cycle + 1;
      exp_q.push_back(e);
    end
    tick();
    s_valid = 1'b0;
    if (ready_last) q_ready = 1'b0;
  endtask

  // pattern[7] is the first bit on the wire; exp_word is the hand-computed result.
  task automatic apply_stimulus(input logic [7:0] pattern, input logic d, input int gap,
                                input logic [7:0] exp_word, input logic pbit, input logic exp_par,
                                input bit push, input bit ready_last);
    send_start(d);
    for (int i = 7; i >= 1; i--) begin
      send_bit(pattern[i], gap);
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit(pattern[0], gap);
    send_last(pbit, gap, exp_word, exp_par, push, ready_last);
`else
    send_last(pattern[0], gap, exp_word, exp_par, push, ready_last);
`endif
  endtask

  task automatic drain();
    int budget;
    q_ready = 1'b1;
    budget  = 0;
    while ((exp_q.size() != 0 || q_valid) && budget < 50) begin
      tick();
      budget++;
    end
    check_output("drain_timeout", (budget < 50) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cycle     = 0;
    presented = 1'b0;
    s_in      = 1'b0;
    s_valid   = 1'b0;
    start     = 1'b0;
    dir       = 1'b0;
    q_ready   = 1'b0;
    reset     = 1'b1;

    // Reset state.
    apply_reset();
    check_output("reset_q_out", {24'd0, q_out}, 32'h00);
    check_output("reset_q_valid", {31'd0, q_valid}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_overrun", {31'd0, overrun}, 32'd0);
    check_output("reset_parity_err", {31'd0, parity_err}, 32'd0);

    // MSB-first 1,0,1,0,0,1,1,0 -> 0xA6, held for 5 cycles with q_ready low.
    apply_stimulus(8'b1010_0110, 1'b0, 0, 8'hA6, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("a6_busy_done", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check_output("a6_held_valid", {31'd0, q_valid}, 32'd1);
    check_output("a6_held_q_out", {24'd0, q_out}, 32'hA6);
    q_ready = 1'b1;
    tick();
    check_output("a6_consumed", {31'd0, q_valid}, 32'd0);

    // Bit order and strobe gaps.
    apply_stimulus(8'b1000_0000, 1'b1, 0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'b1000_0000, 1'b0, 0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'b1000_0000, 1'b1, 2, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'b1000_0000, 1'b0, 2, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'b1010_0110, 1'b1, 0, 8'h65, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Partial word aborted by start; only 0x5A is ever presented.
    send_start(1'b1);
    send_bit(1'b1, 0);
    send_bit(1'b1, 1);
    send_bit(1'b0, 0);
    check_output("abort_busy", {31'd0, busy}, 32'd1);
    apply_stimulus(8'h5A, 1'b0, 0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Overrun: second word dropped while the first is pending.
    q_ready = 1'b0;
    apply_stimulus(8'h11, 1'b0, 0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h22, 1'b0, 0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("ovr_q_out", {24'd0, q_out}, 32'h11);
    check_output("ovr_flag", {31'd0, overrun}, 32'd1);
    drain();
    check_output("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Consume on the completion edge: new word loads, no overrun.
    apply_reset();
    check_output("rst_clears_overrun", {31'd0, overrun}, 32'd0);
    q_ready = 1'b0;
    apply_stimulus(8'h11, 1'b0, 0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h22, 1'b0, 0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    check_output("swap_q_out", {24'd0, q_out}, 32'h22);
    check_output("swap_q_valid", {31'd0, q_valid}, 32'd1);
    check_output("swap_overrun", {31'd0, overrun}, 32'd0);
    drain();

    // Reset in the middle of a frame, then a clean 0xC3 frame.
    send_start(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    apply_reset();
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_q_valid", {31'd0, q_valid}, 32'd0);
    check_output("midrst_q_out", {24'd0, q_out}, 32'h00);
    apply_stimulus(8'hC3, 1'b0, 0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    apply_stimulus(8'hC3, 1'b0, 0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
